// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- single-issue ALU with a valid/ready handshake on both sides.
//
// Single-cycle ops (add, sub, logic, moves, shifts) register their result on
// the accept edge. The optional multiplier is an unsigned shift-add unit that
// retires one multiplier bit per cycle and holds off new work while it runs.
//
// Build option:
//   ALU_PIPE_MUL_EN  defined   -> multiplier (opcode 5'b11111) compiled in
//                    undefined -> 5'b11111 is an undefined opcode (res=0,
//                                 flags=0, one-cycle latency)
//
// Parameters:
//   W   datapath width (8, 16, 32, 64)
//   SW  shift-amount width, taken from B[SW-1:0]
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   producer presents op/A/B
//   in_ready   block can take an operation this cycle
//   op         5-bit opcode
//   A, B       operands (B also carries the shift amount)
//   out_valid  res/flags hold a completed result
//   out_ready  consumer takes the result this cycle
//   res        result
//   flags      {P, C, Z, V}: parity, carry/borrow, zero, signed overflow
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic [3:0]   flags
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_MOVB = 5'b00010,
    OP_AND  = 5'b00100,
    OP_OR   = 5'b00101,
    OP_XOR  = 5'b00110,
    OP_NOTB = 5'b00111,
    OP_MOVA = 5'b10100,
    OP_SHL  = 5'b11001,
    OP_SHR  = 5'b11010,
    OP_SRA  = 5'b11011,
    OP_MUL  = 5'b11111
  } op_e;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU datapath
  // ---------------------------------------------------------------------------
  logic [W:0]    sum_w;
  logic [W:0]    diff_w;
  logic [SW-1:0] sh_amt;
  logic [W-1:0]  alu_res;
  logic          alu_c;
  logic          alu_v;
  logic          alu_def;
  logic [3:0]    alu_flags;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    sum_w   = {1'b0, A} + {1'b0, B};
    // The extra top bit of the difference is the borrow (A < B unsigned).
    diff_w  = {1'b0, A} - {1'b0, B};
    sh_amt  = B[SW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_def = 1'b1;
    case (op)
      OP_ADD: begin
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = (A[W-1] == B[W-1]) && (alu_res[W-1] != A[W-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[W-1:0];
        alu_c   = diff_w[W];
        alu_v   = (A[W-1] != B[W-1]) && (alu_res[W-1] != A[W-1]);
      end
      OP_MOVB: alu_res = B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOTB: alu_res = ~B;
      OP_MOVA: alu_res = A;
      OP_SHL:  alu_res = A << sh_amt;
      OP_SHR:  alu_res = A >> sh_amt;
      OP_SRA:  alu_res = $signed(A) >>> sh_amt;
      // Undefined opcodes (and MUL when the multiplier is not built) yield
      // res=0 with all flags clear, including Z.
      default: alu_def = 1'b0;
    endcase
  end

  assign alu_flags = alu_def ? {^alu_res, alu_c, (alu_res == '0), alu_v} : 4'b0000;

  logic accept;
  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Sequencer and multiplier
  // ---------------------------------------------------------------------------
`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic            start_mul;
  logic            mul_done;
  logic            load_alu;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid || out_ready);
  assign start_mul = accept && (op == OP_MUL);
  assign load_alu  = accept && (op != OP_MUL);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mul_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_mul) begin
          state_d  = S_MUL;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{W{1'b0}}, A};
          mplier_d = B;
        end
      end
      S_MUL: begin
        // One multiplier bit per cycle: add the shifted multiplicand when the
        // current LSB is set, then advance both operands.
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SW'(W - 1)) begin
          mul_done = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and the order of statements is moot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end
`else
  logic load_alu;

  assign in_ready = !out_valid || out_ready;
  assign load_alu = accept;
`endif

  // ---------------------------------------------------------------------------
  // Output register: holds while stalled, clears on consume unless a new
  // result lands on the same edge.
  // ---------------------------------------------------------------------------
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] res_q, res_d;
  logic [3:0]   flags_q, flags_d;

  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    flags_d     = flags_q;
    if (out_ready) out_valid_d = 1'b0;
    if (load_alu) begin
      out_valid_d = 1'b1;
      res_d       = alu_res;
      flags_d     = alu_flags;
    end
`ifdef ALU_PIPE_MUL_EN
    if (mul_done) begin
      out_valid_d = 1'b1;
      res_d       = acc_d[W-1:0];
      flags_d     = {^acc_d[W-1:0], |acc_d[2*W-1:W], (acc_d[W-1:0] == '0), 1'b0};
    end
`endif
  end

  // NOTE: the result registers are reset along with the control bits, so a
  // reset mid-operation leaves nothing stale on res/flags for the consumer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign flags     = flags_q;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter W, default 8: datapath width; legal values 8, 16, 32, 64.
REQ-002 Parameter SW, default $clog2(W): shift-amount width taken from B[SW-1:0].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation presented on op/A/B.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 op  input  5  opcode, see REQ-012.
REQ-008 A  input  W  first operand.
REQ-009 B  input  W  second operand / shift amount.
REQ-010 out_valid  output  1  res/flags hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 res  output  W  result; flags  output  4  {P,C,Z,V}.

Function
REQ-013 Opcodes: 00000 ADD, 00001 SUB, 00010 MOVB, 00100 AND, 00101 OR, 00110 XOR, 00111 NOTB, 10100 MOVA, 11001 SHL, 11010 SHR (logical), 11011 SRA, 11111 MUL; all others undefined -> res=0, flags=0.
REQ-014 Accept: transfer occurs on a rising edge with in_valid && in_ready; inputs are sampled only then.
REQ-015 in_ready = (state==IDLE) && (!out_valid || out_ready); combinational, no dependence on in_valid.
REQ-016 States: IDLE, MUL; IDLE->MUL on accepted MUL; MUL->IDLE after exactly W iteration cycles; other ops stay IDLE.
REQ-017 Non-MUL ops: res/flags registered on accept edge; out_valid high from the next cycle (latency 1).
REQ-018 MUL: unsigned shift-add, one multiplier bit per cycle; res = low W bits of A*B, loaded on the W-th MUL edge; out_valid high W+1 cycles after accept; in_ready low throughout.
REQ-019 Output held stable while out_valid && !out_ready; out_valid clears on out_ready edge unless a new result loads the same edge (back-to-back, full throughput for 1-cycle ops).
REQ-020 P = XOR-reduction of res; Z = (res==0) for all defined ops.
REQ-021 ADD: C = carry out of bit W-1; V = signed overflow.
REQ-022 SUB (A-B): C = borrow (A<B unsigned); V = signed overflow.
REQ-023 MUL: C = upper W bits of product nonzero; V = 0.
REQ-024 All other defined ops: C = 0, V = 0.
REQ-025 Shifts use B[SW-1:0] only; SRA replicates A[W-1]; shift by 0 returns A.
REQ-026 in_valid while in_ready low: operation not taken, no state change; producer holds it.

Reset
REQ-027 reset asserted: state=IDLE, out_valid=0, res=0, flags=0, multiplier accumulator/counter=0, effective immediately.
REQ-028 Reset during MUL aborts the operation; no result is produced after release.
REQ-029 in_ready is 1 in the first cycle after reset deassertion.

Configuration
REQ-030 Macro ALU_PIPE_MUL_EN: defined -> MUL state, accumulator and counter compiled in per REQ-016/018/023.
REQ-031 Without ALU_PIPE_MUL_EN: no MUL state or multiplier logic; 11111 is undefined (res=0, flags=0, latency 1, in_ready never drops for it).

Verification (W=8)
REQ-032 ADD A=0x7F B=0x01, out_ready=1 -> next cycle out_valid=1, res=0x80, flags=4'b1001.
REQ-033 SUB A=0x00 B=0x01 -> res=0xFF, flags=4'b0100.
REQ-034 SRA A=0x80 B=0x03 -> res=0xF0, flags=4'b0000; SHL A=0x01 B=0x0B (amount 3) -> res=0x08, flags=4'b1000.
REQ-035 MUL A=0x10 B=0x10 (macro on) -> in_ready low 8 cycles, out_valid 9 cycles after accept, res=0x00, flags=4'b0110; macro off -> res=0x00, flags=0, latency 1.
REQ-036 Hold out_ready=0 after ADD, keep in_valid=1 with XOR -> res/flags stable, in_ready=0, XOR not accepted until out_ready=1, then streams one result per cycle.
REQ-037 Assert reset 4 cycles into MUL -> out_valid=0, res=0 immediately; after release in_ready=1 and no stale result appears.
